// File: rtl/dtb_pkg.sv
// Shared constants, state encoding and byte-order helper for the device-tree ROM loader.
package dtb_pkg;

  localparam logic [31:0] FDT_MAGIC     = 32'hd00dfeed;
  localparam int unsigned FDT_HDR_BYTES = 40;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StCopy,
    StDone,
    StErr
  } dtb_ld_state_t;

  // FDT header fields are big-endian while the ROM word is little-endian.
  function automatic logic [31:0] be32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/dtb_loader.sv
// Boot-time sequencer: validates the FDT header in the device-tree ROM and streams the blob
// into main memory through a valid/ready write port.
module dtb_loader
  import dtb_pkg::*;
#(
  parameter int unsigned ROM_AW = 9,
  parameter int unsigned MEM_AW = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MEM_AW-1:0] dest_base,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [63:0]       rom_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [63:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ROM_AW:0]   words
);

  dtb_ld_state_t     state_q, state_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [MEM_AW-1:0] base_q, base_d;
  logic [ROM_AW:0]   words_q, words_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [31:0] hdr_magic;
  logic [31:0] hdr_total;
  logic [32:0] hdr_words;
  logic        hdr_bad;
  logic        is_last;

  assign hdr_magic = be32(rom_data[31:0]);
  assign hdr_total = be32(rom_data[63:32]);
  // 33-bit round-up so totalsize near 2^32 cannot wrap into a small word count.
  assign hdr_words = ({1'b0, hdr_total} + 33'd7) >> 3;
  assign hdr_bad   = (hdr_magic != FDT_MAGIC) || (hdr_total < FDT_HDR_BYTES) ||
                     (hdr_words > (33'd1 << ROM_AW));

  assign is_last = ({1'b0, rom_addr_q} == (words_q - (ROM_AW+1)'(1)));

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    base_d     = base_q;
    words_d    = words_q;
    done_d     = done_q;
    err_d      = err_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d    = StHdr;
          rom_addr_d = '0;
          base_d     = dest_base & ~MEM_AW'(7);
          words_d    = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
        end
      end
      StHdr: begin
        if (hdr_bad) begin
          state_d = StErr;
          err_d   = 1'b1;
        end else begin
          state_d    = StCopy;
          words_d    = hdr_words[ROM_AW:0];
          rom_addr_d = '0;
        end
      end
      StCopy: begin
        if (wr_ready) begin
          if (is_last) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            rom_addr_d = rom_addr_q + ROM_AW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rom_addr_q <= '0;
      base_q     <= '0;
      words_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      base_q     <= base_d;
      words_q    <= words_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Write data comes straight from the ROM decode of the registered word index.
  assign rom_addr = rom_addr_q;
  assign wr_valid = (state_q == StCopy);
  assign wr_data  = rom_data;
  assign wr_addr  = (state_q == StCopy) ? base_q + MEM_AW'({rom_addr_q, 3'b000}) : '0;
  assign busy     = (state_q == StHdr) || (state_q == StCopy);
  assign done     = done_q;
  assign err      = err_q;
  assign words    = words_q;

endmodule

// File: tb/tb_dtb_loader.sv
// Randomized self-checking bench for dtb_loader against a header-parsing reference model.
module tb_dtb_loader;

  localparam int unsigned ROM_AW = 9;
  localparam int unsigned MEM_AW = 48;
  localparam int unsigned ROM_WORDS = 512;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [MEM_AW-1:0] dest_base;
  logic [ROM_AW-1:0] rom_addr;
  logic [63:0]       rom_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [MEM_AW-1:0] wr_addr;
  logic [63:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [ROM_AW:0]   words;

  logic [63:0] rom [ROM_WORDS];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  dtb_loader #(.ROM_AW(ROM_AW), .MEM_AW(MEM_AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dest_base (dest_base),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .words     (words)
  );

  // Header word: byte k of the ROM word is bits [8k+7:8k]; each field is stored big-endian.
  function automatic logic [63:0] mk_hdr(input logic [31:0] magic, input logic [31:0] ts);
    logic [63:0] w;
    for (int k = 0; k < 4; k++) begin
      w[8*k +: 8]     = magic[8*(3-k) +: 8];
      w[8*(k+4) +: 8] = ts[8*(3-k) +: 8];
    end
    return w;
  endfunction

  task automatic load_rom(input logic [63:0] hdr);
    for (int i = 0; i < ROM_WORDS; i++) rom[i] = {$urandom(), $urandom()};
    rom[0] = hdr;
  endtask

  // Reference model: parse header from rom[0] byte by byte.
  task automatic model(output bit exp_err, output int exp_words);
    longint magic = 0;
    longint ts = 0;
    for (int k = 0; k < 4; k++) begin
      magic = magic * 256 + longint'(rom[0][8*k +: 8]);
      ts    = ts * 256 + longint'(rom[0][8*(k+4) +: 8]);
    end
    exp_words = int'((ts + 7) / 8);
    exp_err   = (magic != 64'hd00dfeed) || (ts < 40) || (((ts + 7) / 8) > ROM_WORDS);
    if (exp_err) exp_words = 0;
  endtask

  // One start..completion transaction; abort_at >= 0 applies reset once that many words are out.
  task automatic run_copy(input logic [MEM_AW-1:0] base, input int low_pct, input bit pulse_mid,
                          input int abort_at, input string name);
    bit          exp_err;
    int          exp_words;
    int          idx = 0;
    int          n_end = -1;
    bit          stalled = 0;
    bit          pulsed = 0;
    logic [MEM_AW-1:0] held_a, exp_a;
    logic [63:0] held_d;
    model(exp_err, exp_words);
    @(negedge clk);
    start     = 1'b1;
    dest_base = base;
    wr_ready  = 1'b0;
    for (int n = 1; n <= 4000; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 1) begin
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0 || words !== '0 ||
            rom_addr !== '0 || wr_valid !== 1'b0) begin
          n_err++;
          $display("FAIL %s hdr_cycle: busy=%b done=%b err=%b words=%0d valid=%b want 1 0 0 0 0",
                   name, busy, done, err, words, wr_valid);
        end
      end
      if (stalled) begin
        n_vec++;
        if (wr_valid !== 1'b1 || wr_addr !== held_a || wr_data !== held_d) begin
          n_err++;
          $display("FAIL %s stall_hold: valid=%b addr=%h data=%h want 1 %h %h",
                   name, wr_valid, wr_addr, wr_data, held_a, held_d);
        end
      end
      if (wr_valid === 1'b1) begin
        exp_a = (base & ~48'h7) + 48'(idx * 8);
        n_vec++;
        if (exp_err || idx >= exp_words) begin
          n_err++;
          $display("FAIL %s extra_write: idx=%0d words=%0d err_expected=%b",
                   name, idx, exp_words, exp_err);
        end else if (wr_addr !== exp_a || wr_data !== rom[idx]) begin
          n_err++;
          $display("FAIL %s write[%0d]: addr=%h data=%h want %h %h",
                   name, idx, wr_addr, wr_data, exp_a, rom[idx]);
        end
      end
      if (abort_at >= 0 && idx == abort_at && wr_valid === 1'b1) begin
        reset    = 1'b1;
        wr_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (rom_addr !== '0 || wr_valid !== 1'b0 || wr_addr !== '0 || busy !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0 || words !== '0) begin
          n_err++;
          $display("FAIL %s mid_reset: addr=%0d valid=%b waddr=%h busy=%b done=%b err=%b words=%0d",
                   name, rom_addr, wr_valid, wr_addr, busy, done, err, words);
        end
        reset = 1'b0;
        return;
      end
      if (pulse_mid && !pulsed && idx == 50) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      wr_ready = ($urandom_range(99) >= low_pct);
      stalled  = (wr_valid === 1'b1) && !wr_ready;
      held_a   = wr_addr;
      held_d   = wr_data;
      if (wr_valid === 1'b1 && wr_ready) idx++;
      if (done === 1'b1 || err === 1'b1) begin
        n_end = n;
        break;
      end
    end
    wr_ready = 1'b0;
    n_vec++;
    if (n_end < 0) begin
      n_err++;
      $display("FAIL %s timeout: no done/err within budget", name);
      return;
    end
    n_vec++;
    if (err !== exp_err || done !== !exp_err || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s status: err=%b done=%b busy=%b want %b %b 0",
               name, err, done, busy, exp_err, !exp_err);
    end
    n_vec++;
    if (idx != exp_words || int'(words) != exp_words) begin
      n_err++;
      $display("FAIL %s count: writes=%0d words=%0d want %0d", name, idx, words, exp_words);
    end
    if (low_pct == 0) begin
      n_vec++;
      if (n_end != (exp_err ? 2 : 2 + exp_words)) begin
        n_err++;
        $display("FAIL %s latency: end at T+%0d want T+%0d",
                 name, n_end, exp_err ? 2 : 2 + exp_words);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    dest_base = '0;
    wr_ready = 1'b0;
    load_rom(mk_hdr(32'hd00dfeed, 32'h779));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rom_addr !== '0 || wr_valid !== 1'b0 || wr_addr !== '0 || busy !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0 || words !== '0) begin
      n_err++;
      $display("FAIL reset_state: addr=%0d valid=%b waddr=%h busy=%b done=%b err=%b words=%0d",
               rom_addr, wr_valid, wr_addr, busy, done, err, words);
    end
  endtask

  task automatic test_copy();
    load_rom(mk_hdr(32'hd00dfeed, 32'h779));
    n_vec++;
    if (rom[0] !== 64'h79070000edfe0dd0) begin
      n_err++;
      $display("FAIL prod_hdr: rom0=%h want 79070000edfe0dd0", rom[0]);
    end
    run_copy(48'h0000_8000_0000, 0, 1'b0, -1, "prod_copy");
  endtask

  task automatic test_start_ignored();
    run_copy(48'h0000_8000_0000, 0, 1'b1, -1, "start_in_copy");
  endtask

  task automatic test_back_to_back();
    run_copy(48'h0000_8000_0005, 0, 1'b0, -1, "restart_after_done");
  endtask

  task automatic test_backpressure();
    run_copy(48'h0000_8000_0000, 40, 1'b0, -1, "backpressure");
  endtask

  task automatic test_reset_mid();
    run_copy(48'h0000_8000_0000, 0, 1'b0, 100, "reset_mid");
    run_copy(48'h0000_8000_0000, 0, 1'b0, -1, "after_reset");
  endtask

  task automatic test_bad_header();
    load_rom(64'h0);
    run_copy(48'h0000_8000_0000, 0, 1'b0, -1, "bad_magic");
    load_rom(mk_hdr(32'hd00dfeed, 32'h1001));
    run_copy(48'h0000_8000_0000, 0, 1'b0, -1, "too_big");
    load_rom(mk_hdr(32'hd00dfeed, 32'h20));
    run_copy(48'h0000_8000_0000, 0, 1'b0, -1, "too_small");
    load_rom(mk_hdr(32'hd00dfeee, 32'h779));
    run_copy(48'h0000_8000_0000, 0, 1'b0, -1, "magic_off_by_one");
    load_rom(mk_hdr(32'hd00dfeed, 32'hffff_fffd));
    run_copy(48'h0000_8000_0000, 0, 1'b0, -1, "size_wrap");
    load_rom(mk_hdr(32'hd00dfeed, 32'h28));
    run_copy(48'h0000_8000_0000, 0, 1'b0, -1, "min_size");
    load_rom(mk_hdr(32'hd00dfeed, 32'h1000));
    run_copy(48'h0000_8000_0000, 20, 1'b0, -1, "full_rom");
  endtask

  task automatic test_random();
    logic [MEM_AW-1:0] base;
    logic [31:0]       ts;
    for (int r = 0; r < 8; r++) begin
      ts = 32'($urandom_range(4200, 30));
      load_rom(mk_hdr(32'hd00dfeed, ts));
      if (r % 2 == 0) base = 48'hffff_ffff_ff00 + 48'($urandom_range(255));
      else base = {$urandom(), $urandom()} & 48'hffff_ffff_ffff;
      run_copy(base, int'($urandom_range(50)), 1'b0, -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_start_ignored();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_bad_header();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dtb_loader.md
# dtb_loader

Boot-time sequencer for the device-tree ROM (9-bit word address, 64-bit little-endian words, combinational read). On `start` it reads the FDT header, validates magic and size, and streams the blob into main memory through a valid/ready write port. It then reports completion, so firmware finds the DTB at a known DRAM address before releasing harts.

## Interface
Parameters:
- `ROM_AW`, 9: ROM word-address width; ROM depth = 2^ROM_AW words.
- `MEM_AW`, 48: byte-address width of the memory write port.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; honoured only in IDLE, DONE or ERR.
- `dest_base`  in  MEM_AW  destination byte address; sampled on accepted `start`; bits [2:0] treated as zero.
- `rom_addr`  out  ROM_AW  word address to the ROM.
- `rom_data`  in  64  ROM word, valid in the same cycle as `rom_addr`.
- `wr_valid`  out  1  write request.
- `wr_ready`  in  1  memory accepts when `wr_valid & wr_ready`.
- `wr_addr`  out  MEM_AW  byte address, 8-byte aligned.
- `wr_data`  out  64  write data, ROM byte order preserved.
- `busy`  out  1  high in HDR and COPY.
- `done`  out  1  sticky; set on successful completion.
- `err`  out  1  sticky; set on header failure.
- `words`  out  ROM_AW+1  word count decoded from the header; 0 until HDR completes.

## Operation
- FDT header fields are big-endian. Word 0 bytes 0..3 form `magic`, and bytes 4..7 form `totalsize`. Byte k is `rom_data[8k+7:8k]`. Field value = {b0,b1,b2,b3} of the respective 4-byte group.
- States: IDLE, HDR, COPY, DONE, ERR.
- IDLE/DONE/ERR + `start`:
  - go to HDR;
  - clear `done`, `err` and `words`;
  - latch `dest_base`;
  - set `rom_addr`=0.
- HDR (one cycle): evaluate word 0.
  - Error if `magic` ≠ 32'hd00dfeed, `totalsize` < 40, or ceil(`totalsize`/8) > 2^ROM_AW. On error: go to ERR and set `err`.
  - Otherwise `words` = (`totalsize`+7)>>3, a 33-bit add truncated after the range check. Word index i=0, then go to COPY.
- COPY:
  - Outputs: `wr_valid`=1, `rom_addr`=i, `wr_data`=`rom_data`, `wr_addr`=base + (i<<3).
  - On handshake: if i = `words`−1, go to DONE and set `done`; else i++.
  - While `wr_ready`=0, `wr_valid`, `wr_addr` and `wr_data` hold stable. `wr_valid` is never withdrawn before the handshake.
- DONE/ERR: `wr_valid`=0, `rom_addr` holds its last value, and the state waits for `start`.
- `start` while `busy` is ignored.
- `reset` at any time, including mid-COPY, forces IDLE next cycle and leaves no partial-handshake obligation.
- Address arithmetic: `wr_addr` wraps modulo 2^MEM_AW and no error is raised.

## Timing
- Reset values: `rom_addr`=0, `wr_valid`=0, `wr_addr`=0, `busy`=0, `done`=0, `err`=0, `words`=0, state IDLE.
- Start accepted at edge T:
  - HDR occupies cycle T+1;
  - first `wr_valid` in cycle T+2.
- With `wr_ready` held high: one word per cycle, last handshake in cycle T+1+`words`, `done`=1 and `busy`=0 from cycle T+2+`words`.
- Error: `err`=1 and `busy`=0 from cycle T+2; no `wr_valid` is ever asserted.
- `wr_data` is combinational from registered `rom_addr` through the ROM. One ROM decode sits in the path to the memory port; no extra register stage is added.

## Structure
- Package `dtb_pkg` holds:
  - `FDT_MAGIC` = 32'hd00dfeed;
  - `FDT_HDR_BYTES` = 40;
  - the state enum `dtb_ld_state_t`;
  - function `be32(input [31:0])` returning the byte-reversed word.
- No sub-module. The ROM is instantiated by the parent, and this block only drives its address.

## Test plan
- Production ROM, `dest_base`=0x8000_0000, `wr_ready`=1:
  - `words`=240 (`totalsize` 0x779);
  - 240 writes, first to 0x8000_0000 with data 64'h79070000edfe0dd0, last to 0x8000_0778;
  - `done` at T+242.
- Bad-magic ROM (word 0 = 0): `err`=1 at T+2, zero writes, `words`=0.
- `totalsize` = 0x1001 (513 words, exceeds the 512-word ROM): `err`=1; `totalsize` = 0x20: `err`=1.
- Random `wr_ready` back-pressure (≈40% low): data and address stable while stalled; 240 unique, in-order writes; same final memory image as the first test.
- `reset` asserted at word 100 of COPY: next cycle all outputs at reset values. A new `start` then completes a full 240-word copy.
- `start` pulsed during COPY: ignored, count unchanged. `start` after DONE restarts the copy and clears `done` on that edge.
